// File: rtl/fifo_top.sv
// Single-clock first-word-fall-through FIFO with full/empty backpressure.
// Optional sticky OVERFLOW/UNDERFLOW outputs when FIFO_ERR_FLAGS_EN is defined.
module fifo_top #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic                  R_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  FULL,
    output logic                  EMPTY
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_en;
    logic                  rd_en;

    // Requests are qualified by the flags seen before the edge.
    assign wr_en = W_INC & ~FULL;
    assign rd_en = R_INC & ~EMPTY;

    assign EMPTY   = (wr_ptr == rd_ptr);
    assign FULL    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign RD_DATA = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // Storage is intentionally not reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (W_INC && FULL) begin
                OVERFLOW <= 1'b1;
            end
            if (R_INC && EMPTY) begin
                UNDERFLOW <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_top.sv
// Directed self-checking bench for fifo_top (8x8 FWFT FIFO).
module tb_fifo_top;

    logic       clk;
    logic       rst;
    logic       w_inc;
    logic       r_inc;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    fifo_top #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .CLK      (clk),
        .RST      (rst),
        .W_INC    (w_inc),
        .R_INC    (r_inc),
        .WR_DATA  (wr_data),
        .RD_DATA  (rd_data),
        .FULL     (full),
        .EMPTY    (empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .OVERFLOW (overflow),
        .UNDERFLOW(underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; outputs are stable at return (#1 after the edge).
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        w_inc   = w;
        r_inc   = r;
        wr_data = d;
        @(posedge clk);
        #1;
        w_inc = 1'b0;
        r_inc = 1'b0;
    endtask

    logic [7:0] vals [10];
    int wi, ri, cyc;

    initial begin
        clk = 1'b0; rst = 1'b1; w_inc = 1'b0; r_inc = 1'b0; wr_data = 8'h00;
        vals[0] = 8'h24; vals[1] = 8'h81; vals[2] = 8'h09; vals[3] = 8'h63; vals[4] = 8'h0D;
        vals[5] = 8'h8D; vals[6] = 8'h65; vals[7] = 8'h12; vals[8] = 8'h01; vals[9] = 8'h0D;

        // Reset takes effect without a clock edge
        #2;
        chk("rst_empty", 8'(empty), 8'h01);
        chk("rst_full",  8'(full),  8'h00);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 8'h00);
        chk("rd_at_empty_empty", 8'(empty), 8'h01);
        chk("rd_at_empty_full",  8'(full),  8'h00);

        // Ordering: writer every cycle (flag-respecting), reader every 3rd cycle
        wi = 0; ri = 0; cyc = 0;
        while ((ri < 10) && (cyc < 200)) begin
            @(negedge clk);
            w_inc = 1'b0; r_inc = 1'b0;
            if ((wi < 10) && !full) begin
                w_inc = 1'b1; wr_data = vals[wi]; wi++;
            end
            if (((cyc % 3) == 2) && !empty) begin
                chk($sformatf("order_%0d", ri), rd_data, vals[ri]);
                r_inc = 1'b1; ri++;
            end
            @(posedge clk);
            #1;
            w_inc = 1'b0; r_inc = 1'b0;
            cyc++;
        end
        chk("order_count", 8'(ri), 8'd10);
        chk("order_end_empty", 8'(empty), 8'h01);

        // Fill: 8 writes, 9th ignored, drain 8
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'h10 + 8'(i));
            chk("fill_not_empty", 8'(empty), 8'h00);
        end
        chk("fill_full", 8'(full), 8'h01);
        step(1'b1, 1'b0, 8'hFF);
        chk("ovf_full_held", 8'(full), 8'h01);
        chk("ovf_head_intact", rd_data, 8'h10);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_%0d", i), rd_data, 8'h10 + 8'(i));
            step(1'b0, 1'b1, 8'h00);
            chk("drain_not_full", 8'(full), 8'h00);
        end
        chk("drain_empty", 8'(empty), 8'h01);

        // Simultaneous read+write at FULL: only read accepted
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
        chk("sim_pre_full", 8'(full), 8'h01);
        step(1'b1, 1'b1, 8'hAA);
        chk("sim_full_clears", 8'(full), 8'h00);
        chk("sim_full_head", rd_data, 8'h31);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("sim_drain_%0d", i), rd_data, 8'h30 + 8'(i));
            step(1'b0, 1'b1, 8'h00);
        end
        chk("sim_aa_not_stored", 8'(empty), 8'h01);

        // Simultaneous read+write at EMPTY: only write accepted
        step(1'b1, 1'b1, 8'hAA);
        chk("sim_empty_clears", 8'(empty), 8'h00);
        chk("sim_empty_data", rd_data, 8'hAA);
        chk("sim_empty_full", 8'(full), 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk("sim_empty_pop", 8'(empty), 8'h01);

        // Wrap: 20 write/read pairs through the 8-deep storage
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 8'h50 + 8'(i * 3));
            chk($sformatf("wrap_data_%0d", i), rd_data, 8'h50 + 8'(i * 3));
            step(1'b0, 1'b1, 8'h00);
        end
        chk("wrap_end_empty", 8'(empty), 8'h01);
        chk("wrap_end_full",  8'(full),  8'h00);

        // Reset mid-operation discards queued words
        step(1'b1, 1'b0, 8'hC1);
        step(1'b1, 1'b0, 8'hC2);
        step(1'b1, 1'b0, 8'hC3);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_empty", 8'(empty), 8'h01);
        #1 rst = 1'b0;
        step(1'b1, 1'b0, 8'hD7);
        chk("midrst_new_head", rd_data, 8'hD7);
        step(1'b0, 1'b1, 8'h00);
        chk("midrst_drained", 8'(empty), 8'h01);

`ifdef FIFO_ERR_FLAGS_EN
        // Sticky error flags
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        chk("err_rst_ovf", 8'(overflow),  8'h00);
        chk("err_rst_udf", 8'(underflow), 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(i));
        chk("err_no_ovf_yet", 8'(overflow), 8'h00);
        step(1'b1, 1'b0, 8'hEE);
        chk("err_ovf_set", 8'(overflow), 8'h01);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
        chk("err_ovf_sticky", 8'(overflow),  8'h01);
        chk("err_no_udf_yet", 8'(underflow), 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk("err_udf_set", 8'(underflow), 8'h01);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("err_clr_ovf", 8'(overflow),  8'h00);
        chk("err_clr_udf", 8'(underflow), 8'h00);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
